bcd_seq_converter: RTL and testbench

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

---
 rtl/bcd_seq_converter_if.sv | 45 ++++
 rtl/bcd_seq_converter.sv | 136 +++++++++++++
 tb/tb_bcd_seq_converter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_seq_converter_if
//   Handshake bundle between a request producer / result consumer and the
//   sequential binary-to-BCD converter.
//
//   Parameters
//     BIN_W   width of the binary request value
//     DIGITS  number of BCD digits in the result
//
//   Signals
//     in_valid / in_ready   request handshake
//     bin_in, signed_en     request payload (value, two's complement flag)
//     out_valid / out_ready result handshake
//     bcd_out               result digits, digit k at [4k+3:4k], k=0 = ones
//     neg_out               result is negative (bcd_out holds the magnitude)
//     ovf_out               magnitude did not fit in DIGITS digits
//
//   Modports
//     master  producer/consumer side (testbench or upstream logic)
//     slave   converter side
// ---------------------------------------------------------------------------
interface bcd_seq_converter_if #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  signed_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg_out;
  logic                  ovf_out;

  modport master (
    output in_valid, bin_in, signed_en, out_ready,
    input  in_ready, out_valid, bcd_out, neg_out, ovf_out
  );

  modport slave (
    input  in_valid, bin_in, signed_en, out_ready,
    output in_ready, out_valid, bcd_out, neg_out, ovf_out
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_seq_converter
//   Sequential binary-to-BCD converter using the double-dabble algorithm,
//   one magnitude bit per clock. A request is accepted in IDLE, converted in
//   BIN_W SHIFT cycles, and the result is presented in DONE until the
//   consumer takes it.
//
//   Parameters
//     BIN_W   binary input width (1..32)
//     DIGITS  BCD output digits (1..10)
//
//   Ports
//     clk     clock, all state changes on the rising edge
//     rst_n   asynchronous active-low reset
//     bus     bcd_seq_converter_if.slave handshake bundle
//
//   Signed requests are converted as sign + magnitude. When the magnitude
//   exceeds 10^DIGITS-1 the result is the magnitude modulo 10^DIGITS and
//   ovf_out is set.
// ---------------------------------------------------------------------------
module bcd_seq_converter #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_seq_converter_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   mag_reg,   mag_next;
  logic [ACC_W-1:0]   acc_reg,   acc_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic               neg_reg,   neg_next;
  logic               ovf_reg,   ovf_next;

  logic [ACC_W-1:0]   acc_adj;
  logic [BIN_W-1:0]   mag_in;
  logic               neg_in;

  // Sign/magnitude split of the incoming request. The most negative value
  // negates to itself, which read as unsigned is exactly 2^(BIN_W-1).
  assign neg_in = bus.signed_en & bus.bin_in[BIN_W-1];
  assign mag_in = neg_in ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;

  // Double-dabble correction: every digit >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] digit;
      assign digit = acc_reg[4*gi +: 4];
      assign acc_adj[4*gi +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mag_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mag_reg   <= mag_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      neg_reg   <= neg_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mag_next   = mag_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    neg_next   = neg_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mag_next   = mag_in;
          neg_next   = neg_in;
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        // Whatever leaves the top digit is a multiple of 10^DIGITS; dropping
        // it leaves the result modulo 10^DIGITS and flags the overflow.
        acc_next = {acc_adj[ACC_W-2:0], mag_reg[BIN_W-1]};
        ovf_next = ovf_reg | acc_adj[ACC_W-1];
        mag_next = mag_reg << 1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result outputs are gated by DONE so no partial accumulator is visible.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.bcd_out   = (state_reg == DONE) ? acc_reg : '0;
  assign bus.neg_out   = (state_reg == DONE) ? neg_reg : 1'b0;
  assign bus.ovf_out   = (state_reg == DONE) ? ovf_reg : 1'b0;

endmodule

// File: tb/tb_bcd_seq_converter.sv
module tb_bcd_seq_converter;

  localparam int N_SWEEP = 1000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.BIN_W(13), .DIGITS(4)) ia ();
  bcd_seq_converter_if #(.BIN_W(13), .DIGITS(3)) ib ();

  bcd_seq_converter #(.BIN_W(13), .DIGITS(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  bcd_seq_converter #(.BIN_W(13), .DIGITS(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decimal conversion by repeated division.
  function automatic logic [15:0] ref_bcd(input int unsigned m);
    logic [15:0] r;
    int unsigned v;
    r = '0;
    v = m;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One full transaction on dut_a. Called at posedge+1 (or mid-cycle).
  task automatic conv_a(input string tag, input logic [12:0] bin, input logic sgn,
                        input logic [15:0] exp_bcd, input logic exp_neg,
                        input logic hold_ready);
    int n;
    ia.bin_in    = bin;
    ia.signed_en = sgn;
    ia.in_valid  = 1'b1;
    ia.out_ready = hold_ready;
    chk({tag, "/in_ready"}, ia.in_ready, 1);
    @(posedge clk); #1;
    // Scramble request inputs during the conversion; they must be ignored.
    ia.in_valid  = 1'b0;
    ia.bin_in    = 13'($urandom);
    ia.signed_en = 1'($urandom);
    n = 0;
    while (!ia.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, n, 13);
    chk({tag, "/bcd"}, ia.bcd_out, exp_bcd);
    chk({tag, "/neg"}, ia.neg_out, exp_neg);
    chk({tag, "/ovf"}, ia.ovf_out, 0);
    $display("xact %s bin=%h sgn=%0d bcd=%h neg=%0d ovf=%0d lat=%0d",
             tag, bin, sgn, ia.bcd_out, ia.neg_out, ia.ovf_out, n);
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    ia.out_ready = 1'b0;
    chk({tag, "/post_valid"}, ia.out_valid, 0);
    chk({tag, "/post_ready"}, ia.in_ready, 1);
  endtask

  task automatic conv_b(input string tag, input logic [12:0] bin, input logic sgn,
                        input logic [11:0] exp_bcd, input logic exp_neg,
                        input logic exp_ovf);
    int n;
    ib.bin_in    = bin;
    ib.signed_en = sgn;
    ib.in_valid  = 1'b1;
    ib.out_ready = 1'b0;
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    n = 0;
    while (!ib.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, n, 13);
    chk({tag, "/bcd"}, ib.bcd_out, exp_bcd);
    chk({tag, "/neg"}, ib.neg_out, exp_neg);
    chk({tag, "/ovf"}, ib.ovf_out, exp_ovf);
    $display("xact %s bin=%h sgn=%0d bcd=%h neg=%0d ovf=%0d lat=%0d",
             tag, bin, sgn, ib.bcd_out, ib.neg_out, ib.ovf_out, n);
    ib.out_ready = 1'b1;
    @(posedge clk); #1;
    ib.out_ready = 1'b0;
    chk({tag, "/post_ready"}, ib.in_ready, 1);
  endtask

  initial begin
    logic [15:0] q_bcd[$];
    logic        q_neg[$];
    logic [15:0] e_bcd;
    logic        e_neg;
    int          sent, got, cyc, n;
    int unsigned mag;
    logic        acc_pend;

    ia.in_valid = 1'b0; ia.bin_in = '0; ia.signed_en = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.bin_in = '0; ib.signed_en = 1'b0; ib.out_ready = 1'b0;

    // Reset state, checked before any clock edge to show it is asynchronous.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset/in_ready", ia.in_ready, 1);
    chk("reset/out_valid", ia.out_valid, 0);
    chk("reset/bcd", ia.bcd_out, 0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed conversions, 4 digits.
    conv_a("u8191", 13'd8191, 1'b0, 16'h8191, 1'b0, 1'b1);
    conv_a("s1FFF", 13'h1FFF, 1'b1, 16'h0001, 1'b1, 1'b0);
    conv_a("s1000", 13'h1000, 1'b1, 16'h4096, 1'b1, 1'b0);
    conv_a("u1000", 13'h1000, 1'b0, 16'h4096, 1'b0, 1'b0);
    conv_a("s1F9C", 13'h1F9C, 1'b1, 16'h0100, 1'b1, 1'b0);
    conv_a("u1234", 13'd1234, 1'b0, 16'h1234, 1'b0, 1'b0);
    conv_a("s0", 13'd0, 1'b1, 16'h0000, 1'b0, 1'b0);
    conv_a("u1", 13'd1, 1'b0, 16'h0001, 1'b0, 1'b1);

    // Overflow behaviour with 3 digits.
    conv_b("d3_1234", 13'd1234, 1'b0, 12'h234, 1'b0, 1'b1);
    conv_b("d3_999", 13'd999, 1'b0, 12'h999, 1'b0, 1'b0);
    conv_b("d3_1000", 13'd1000, 1'b0, 12'h000, 1'b0, 1'b1);
    conv_b("d3_s1000", 13'h1000, 1'b1, 12'h096, 1'b1, 1'b1);

    // Backpressure: result held 20 cycles while request inputs toggle.
    ia.bin_in = 13'd4321; ia.signed_en = 1'b0; ia.in_valid = 1'b1; ia.out_ready = 1'b0;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    n = 0;
    while (!ia.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp/latency", n, 13);
    for (int i = 0; i < 20; i++) begin
      ia.in_valid  = 1'($urandom);
      ia.bin_in    = 13'($urandom);
      ia.signed_en = 1'($urandom);
      chk("bp/bcd", ia.bcd_out, 16'h4321);
      chk("bp/in_ready", ia.in_ready, 0);
      chk("bp/out_valid", ia.out_valid, 1);
      @(posedge clk); #1;
    end
    $display("xact bp bin=4321 bcd=%h held 20 cycles", ia.bcd_out);
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    ia.out_ready = 1'b0;
    chk("bp/after_valid", ia.out_valid, 0);
    chk("bp/after_ready", ia.in_ready, 1);
    @(posedge clk); #1;
    chk("bp/no_dup", ia.out_valid, 0);

    // Reset during SHIFT step 6.
    ia.bin_in = 13'd8191; ia.signed_en = 1'b0; ia.in_valid = 1'b1;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("rst_shift/in_ready_before", ia.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_shift/in_ready", ia.in_ready, 1);
    chk("rst_shift/out_valid", ia.out_valid, 0);
    chk("rst_shift/bcd", ia.bcd_out, 0);
    #1 rst_n = 1'b1;
    conv_a("rst_then0", 13'd0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Reset while a result is waiting in DONE.
    ia.bin_in = 13'd777; ia.signed_en = 1'b0; ia.in_valid = 1'b1;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    n = 0;
    while (!ia.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_done/bcd_before", ia.bcd_out, 16'h0777);
    rst_n = 1'b0;
    #1;
    chk("rst_done/out_valid", ia.out_valid, 0);
    chk("rst_done/bcd", ia.bcd_out, 0);
    chk("rst_done/in_ready", ia.in_ready, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random sweep with random request gaps and consumer stalls.
    sent = 0; got = 0; cyc = 0; acc_pend = 1'b0;
    while (got < N_SWEEP && cyc < 60000) begin
      if (acc_pend) ia.in_valid = 1'b0;
      if (!ia.in_valid && sent < N_SWEEP && $urandom_range(0, 2) == 0) begin
        ia.bin_in    = 13'($urandom);
        ia.signed_en = 1'($urandom);
        ia.in_valid  = 1'b1;
      end
      ia.out_ready = ($urandom_range(0, 3) != 0);
      acc_pend = ia.in_valid && ia.in_ready;
      if (acc_pend) begin
        if (ia.signed_en && ia.bin_in[12]) begin
          mag = 8192 - int'(ia.bin_in);
          q_neg.push_back(1'b1);
        end else begin
          mag = int'(ia.bin_in);
          q_neg.push_back(1'b0);
        end
        q_bcd.push_back(ref_bcd(mag));
        sent++;
      end
      if (ia.out_valid && ia.out_ready) begin
        chk("sweep/expected_pending", (q_bcd.size() != 0), 1);
        if (q_bcd.size() != 0) begin
          e_bcd = q_bcd.pop_front();
          e_neg = q_neg.pop_front();
          chk("sweep/bcd", ia.bcd_out, e_bcd);
          chk("sweep/neg", ia.neg_out, e_neg);
          chk("sweep/ovf", ia.ovf_out, 0);
          $display("xact sweep %0d bcd=%h neg=%0d exp=%h/%0d",
                   got, ia.bcd_out, ia.neg_out, e_bcd, e_neg);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ia.in_valid  = 1'b0;
    ia.out_ready = 1'b0;
    chk("sweep/count", got, N_SWEEP);
    chk("sweep/leftover", q_bcd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
